simple_tester: RTL and testbench

SIMPLE_TESTER -- requirements
Module: simple_tester

---
 rtl/simple_tester_if.sv | 27 ++
 rtl/simple_tester.sv | 118 +++++++++++
 tb/tb_simple_tester.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/simple_tester_if.sv
// Signal bundle between the tester and the combinational block under test.
// The master side is the tester itself; the slave side is whatever supplies
// START and the logic block's responses.
interface simple_tester_if;
  logic       start;
  logic       drv_in1;
  logic       drv_in2;
  logic       obs_and;
  logic       obs_or;
  logic       obs_not_in1;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [3:0] fail_vec;
  logic [1:0] state_dbg;

  modport master (
    input  start, obs_and, obs_or, obs_not_in1,
    output drv_in1, drv_in2, busy, done, pass, err_cnt, fail_vec, state_dbg
  );

  modport slave (
    output start, obs_and, obs_or, obs_not_in1,
    input  drv_in1, drv_in2, busy, done, pass, err_cnt, fail_vec, state_dbg
  );
endinterface

// File: rtl/simple_tester.sv
// Built-in tester for a two-input AND/OR/NOT block. It drives the four input
// combinations 00,01,10,11 in order, holds each for SETTLE+1 cycles, samples
// the three responses on the last edge of each vector and accumulates a
// mismatch count plus a per-vector fail mask.
// START is a level request: it is taken on any rising edge while IDLE and
// ignored in RUN and FIN. BUSY marks the RUN phase and DONE is a one-cycle
// pulse in FIN, after which PASS/ERR_CNT/FAIL_VEC are stable until the next
// accepted START.
module simple_tester #(
  parameter int unsigned SETTLE = 2
) (
  input logic            clk,
  input logic            rst,
  simple_tester_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] vec_idx;
  logic [3:0] settle_cnt;
  logic [3:0] err_cnt;
  logic [3:0] fail_vec;
  logic       pass;

  logic       accept;
  logic       sample_now;
  logic       last_vec;
  logic       exp_and;
  logic       exp_or;
  logic       exp_not;
  logic [1:0] mism_cnt;
  logic [3:0] err_sum;

  // Qualifiers: START acceptance, sample edge of the current vector, last vector.
  always_comb begin
    accept     = (state == IDLE) && bus.start;
    sample_now = (state == RUN) && (settle_cnt == 4'(SETTLE));
    last_vec   = (vec_idx == 2'd3);
  end

  // Expected responses for the vector being driven and the number of bad bits.
  always_comb begin
    exp_and  = vec_idx[1] & vec_idx[0];
    exp_or   = vec_idx[1] | vec_idx[0];
    exp_not  = ~vec_idx[1];
    mism_cnt = {1'b0, bus.obs_and ^ exp_and}
             + {1'b0, bus.obs_or ^ exp_or}
             + {1'b0, bus.obs_not_in1 ^ exp_not};
    err_sum  = err_cnt + {2'b00, mism_cnt};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: FIN lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (sample_now && last_vec) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencing counters and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
      err_cnt    <= 4'd0;
      fail_vec   <= 4'd0;
      pass       <= 1'b0;
    end else if (accept) begin
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
      err_cnt    <= 4'd0;
      fail_vec   <= 4'd0;
      pass       <= 1'b0;
    end else if (state == RUN) begin
      if (sample_now) begin
        err_cnt    <= err_sum;
        settle_cnt <= 4'd0;
        if (mism_cnt != 2'd0) fail_vec[vec_idx] <= 1'b1;
        // PASS is decided on the edge that enters FIN, using the final count.
        if (last_vec) pass <= (err_sum == 4'd0);
        else          vec_idx <= vec_idx + 2'd1;
      end else begin
        settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  // Outputs decode directly from registers; the stimulus is quiet outside RUN.
  always_comb begin
    bus.busy      = (state == RUN);
    bus.done      = (state == FIN);
    bus.drv_in1   = (state == RUN) ? vec_idx[1] : 1'b0;
    bus.drv_in2   = (state == RUN) ? vec_idx[0] : 1'b0;
    bus.pass      = pass;
    bus.err_cnt   = err_cnt;
    bus.fail_vec  = fail_vec;
    bus.state_dbg = state;
  end

endmodule

// File: tb/tb_simple_tester.sv
// Directed bench for simple_tester: two instances (SETTLE=2 and SETTLE=0),
// each attached to a behavioural logic block with selectable faults.
module tb_simple_tester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   mode_a = 0;
  int   mode_b = 0;
  logic use_b = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  simple_tester_if ifa ();
  simple_tester_if ifb ();

  // Logic block model: 0 = correct, 1 = AND stuck at 1, 2 = all outputs inverted.
  function automatic logic [2:0] blk(input logic i1, input logic i2, input int mode);
    logic [2:0] r;
    r = {i1 & i2, i1 | i2, ~i1};
    if (mode == 1) r[2] = 1'b1;
    if (mode == 2) r = ~r;
    return r;
  endfunction

  assign ifa.start = start_a;
  assign ifb.start = start_b;
  assign {ifa.obs_and, ifa.obs_or, ifa.obs_not_in1} = blk(ifa.drv_in1, ifa.drv_in2, mode_a);
  assign {ifb.obs_and, ifb.obs_or, ifb.obs_not_in1} = blk(ifb.drv_in1, ifb.drv_in2, mode_b);

  simple_tester #(.SETTLE(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  simple_tester #(.SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  // Outputs of whichever instance is under test.
  logic       o_busy, o_done, o_pass;
  logic [1:0] o_drv;
  logic [3:0] o_err, o_fail;
  assign o_busy = use_b ? ifb.busy : ifa.busy;
  assign o_done = use_b ? ifb.done : ifa.done;
  assign o_pass = use_b ? ifb.pass : ifa.pass;
  assign o_drv  = use_b ? {ifb.drv_in1, ifb.drv_in2} : {ifa.drv_in1, ifa.drv_in2};
  assign o_err  = use_b ? ifb.err_cnt : ifa.err_cnt;
  assign o_fail = use_b ? ifb.fail_vec : ifa.fail_vec;

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (use_b) start_b = v;
    else       start_a = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {7'd0, o_busy}, 8'd0);
    check({tag, "_done"}, {7'd0, o_done}, 8'd0);
    check({tag, "_pass"}, {7'd0, o_pass}, 8'd0);
    check({tag, "_drv"},  {6'd0, o_drv},  8'd0);
    check({tag, "_err"},  {4'd0, o_err},  8'd0);
    check({tag, "_fail"}, {4'd0, o_fail}, 8'd0);
  endtask

  // Wait (bounded) for DONE; cyc returns the number of edges waited.
  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (o_done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check("done_timeout", 8'd0, 8'd1);
  endtask

  // One full sequence with per-cycle stimulus checks and final result checks.
  // noise pulses START once mid-RUN and once in FIN; neither may restart.
  task automatic run_seq(input int settle, input logic [3:0] exp_err,
                         input logic [3:0] exp_fail, input logic exp_pass,
                         input logic noise);
    int n;
    logic [1:0] exp_drv;
    n = 4 * (settle + 1);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    for (int j = 0; j < n; j++) begin
      exp_drv = 2'(j / (settle + 1));
      check("run_busy", {7'd0, o_busy}, 8'd1);
      check("run_done", {7'd0, o_done}, 8'd0);
      check("run_drv",  {6'd0, o_drv},  {6'd0, exp_drv});
      if (j == 0) begin
        check("clr_err",  {4'd0, o_err},  8'd0);
        check("clr_fail", {4'd0, o_fail}, 8'd0);
        check("clr_pass", {7'd0, o_pass}, 8'd0);
      end
      if (noise && j == 4) set_start(1'b1);
      if (noise && j == 5) set_start(1'b0);
      @(negedge clk);
    end
    check("fin_done", {7'd0, o_done}, 8'd1);
    check("fin_busy", {7'd0, o_busy}, 8'd0);
    check("fin_drv",  {6'd0, o_drv},  8'd0);
    check("fin_err",  {4'd0, o_err},  {4'd0, exp_err});
    check("fin_fail", {4'd0, o_fail}, {4'd0, exp_fail});
    check("fin_pass", {7'd0, o_pass}, {7'd0, exp_pass});
    if (noise) set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    check("post_done", {7'd0, o_done}, 8'd0);
    check("post_busy", {7'd0, o_busy}, 8'd0);
    @(negedge clk);
    check("idle_done", {7'd0, o_done}, 8'd0);
    check("idle_busy", {7'd0, o_busy}, 8'd0);
    check("hold_err",  {4'd0, o_err},  {4'd0, exp_err});
    check("hold_pass", {7'd0, o_pass}, {7'd0, exp_pass});
  endtask

  initial begin
    int cyc;
    // Reset state of both instances.
    @(negedge clk);
    @(negedge clk);
    use_b = 1'b0;
    #1 check_all_zero("rst_a");
    use_b = 1'b1;
    #1 check_all_zero("rst_b");
    use_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Correct block, SETTLE=2.
    mode_a = 0;
    run_seq(2, 4'd0, 4'b0000, 1'b1, 1'b0);

    // AND stuck at 1, SETTLE=0: vectors 00,01,10 each show one bad bit.
    use_b = 1'b1;
    mode_b = 1;
    run_seq(0, 4'd3, 4'b0111, 1'b0, 1'b0);

    // All responses inverted: three bad bits per vector.
    mode_b = 2;
    run_seq(0, 4'd12, 4'b1111, 1'b0, 1'b0);
    mode_b = 0;
    run_seq(0, 4'd0, 4'b0000, 1'b1, 1'b0);
    use_b = 1'b0;

    // START pulses in RUN and FIN are ignored.
    run_seq(2, 4'd0, 4'b0000, 1'b1, 1'b1);

    // START held high: back-to-back runs with one IDLE cycle between.
    set_start(1'b1);
    @(negedge clk);
    wait_done(20, cyc);
    check("held_lat1", 8'(cyc), 8'd12);
    check("held_pass1", {7'd0, o_pass}, 8'd1);
    @(negedge clk);
    check("held_gap_busy", {7'd0, o_busy}, 8'd0);
    check("held_gap_done", {7'd0, o_done}, 8'd0);
    @(negedge clk);
    check("held_restart", {7'd0, o_busy}, 8'd1);
    set_start(1'b0);
    wait_done(20, cyc);
    check("held_lat2", 8'(cyc), 8'd12);
    check("held_pass2", {7'd0, o_pass}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    check("held_stop", {7'd0, o_busy}, 8'd0);

    // Asynchronous reset in the middle of vector 2 with errors accumulated.
    mode_a = 2;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (7) @(negedge clk);
    check("pre_rst_drv",  {6'd0, o_drv},  8'd2);
    check("pre_rst_err",  {4'd0, o_err},  8'd6);
    check("pre_rst_fail", {4'd0, o_fail}, 8'd3);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_hold_done", {7'd0, o_done}, 8'd0);
      check("rst_hold_busy", {7'd0, o_busy}, 8'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_idle_busy", {7'd0, o_busy}, 8'd0);
    check("rst_idle_done", {7'd0, o_done}, 8'd0);
    mode_a = 0;
    run_seq(2, 4'd0, 4'b0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
